multicycle_control: RTL and testbench

- Parametrised multicycle successor to the single-cycle instruction decoder.
- Sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives datapath strobes per cycle, waits on a memory ready handshake, guards memory waits with a watchdog and traps illegal opcodes.
- Sits between instruction register/PC/register file/ALU/unified memory and replaces per-instruction combinational control.

---
 rtl/multicycle_control_if.sv | 44 ++++
 rtl/multicycle_control.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Bus between the multicycle controller and the MIPS datapath.
// The master side is the controller: it samples the instruction/status
// inputs and drives the datapath strobes and status outputs.
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  // Datapath to controller
  logic [31:0]      inst;
  logic             mem_ready;
  logic             zero;
  logic             stall;
  // Controller to datapath
  logic             pc_wr;
  logic [1:0]       pc_src;
  logic             ir_wr;
  logic             i_or_d;
  logic             mem_rd;
  logic             mem_wr;
  logic             reg_wr;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             ext_op;
  logic [2:0]       state;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] retired;

  modport master (
    input  inst, mem_ready, zero, stall,
    output pc_wr, pc_src, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, state,
           illegal, timeout, retired
  );

  modport slave (
    output inst, mem_ready, zero, stall,
    input  pc_wr, pc_src, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, state,
           illegal, timeout, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes combinationally from state and the latched
// opcode, guards memory waits with a watchdog and traps bad opcodes.
// Optional retired-instruction counter: define CTRL_RETIRE_CNT_EN.
module multicycle_control #(
  parameter int TIMEOUT_W = 4,
  parameter int CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_IDLE   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Watchdog value seen on the last tolerated not-ready cycle
  // (the current cycle is then the (2^W-1)-th consecutive wait).
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               r_state;
  logic [5:0]           r_opcode;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_illegal;
  logic                 r_timeout;

  state_t               w_next;
  logic                 w_set_ill;
  logic                 w_set_to;
  logic                 w_wait;
  logic                 w_dec_legal;
  logic [5:0]           w_dec_op;
  logic                 w_unused_inst;

  assign w_dec_op      = bus.inst[31:26];
  assign w_unused_inst = ^bus.inst[25:0];
  assign w_wait        = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready;

  // Opcode legality check on the live IR contents during DECODE
  always_comb begin
    case (w_dec_op)
      OP_R, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: w_dec_legal = 1'b1;
      default:                                                    w_dec_legal = 1'b0;
    endcase
  end

  // Next-state selection, including watchdog and illegal-opcode traps
  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    w_set_to  = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_next = S_DECODE;
        end else if (r_wd == WD_LAST) begin
          w_next   = S_TRAP;
          w_set_to = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_dec_op == OP_J) begin
          w_next = S_FETCH;
        end else if (!w_dec_legal) begin
          w_next    = S_TRAP;
          w_set_ill = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_opcode)
          OP_LW, OP_SW:   w_next = S_MEM;
          OP_BEQ, OP_BNE: w_next = S_FETCH;
          default:        w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          w_next = (r_opcode == OP_LW) ? S_WB : S_FETCH;
        end else if (r_wd == WD_LAST) begin
          w_next   = S_TRAP;
          w_set_to = 1'b1;
        end
      end
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_IDLE;
    endcase
  end

  // State, opcode latch, watchdog and sticky flags; everything holds on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_opcode  <= 6'd0;
      r_wd      <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else if (!bus.stall) begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.inst[31:26];
      // Only consecutive waits in the same state count
      if (w_wait && (w_next == r_state)) r_wd <= r_wd + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
      else                               r_wd <= '0;
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_to)  r_timeout <= 1'b1;
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  // An instruction retires whenever control returns to FETCH from a real stage
  assign w_retire = !bus.stall && (w_next == S_FETCH) &&
                    (r_state != S_IDLE) && (r_state != S_FETCH);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.retired = r_retired;
`else
  localparam int unused_cnt_w = CNT_W;
  assign bus.retired = '0;
`endif

  assign bus.state   = r_state;
  assign bus.illegal = r_illegal;
  assign bus.timeout = r_timeout;

  // Datapath strobes from state/opcode; stall suppresses every write/request
  always_comb begin
    bus.pc_wr      = 1'b0;
    bus.pc_src     = 2'b00;
    bus.ir_wr      = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.reg_wr     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.ext_op     = 1'b1;
    case (r_state)
      S_IDLE: bus.ext_op = 1'b0;
      S_FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          bus.ir_wr = 1'b1;
          bus.pc_wr = 1'b1;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        if (w_dec_op == OP_J) begin
          bus.pc_wr  = 1'b1;
          bus.pc_src = 2'b10;
        end
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        case (r_opcode)
          OP_R: bus.alu_op = 2'b10;
          OP_ANDI: begin
            bus.alu_src_b = 2'b10;
            bus.alu_op    = 2'b11;
            bus.ext_op    = 1'b0;
          end
          OP_BEQ: begin
            bus.alu_op = 2'b01;
            bus.pc_src = 2'b01;
            bus.pc_wr  = bus.zero;
          end
          OP_BNE: begin
            bus.alu_op = 2'b01;
            bus.pc_src = 2'b01;
            bus.pc_wr  = ~bus.zero;
          end
          default: bus.alu_src_b = 2'b10;
        endcase
      end
      S_MEM: begin
        bus.i_or_d = 1'b1;
        bus.mem_rd = (r_opcode == OP_LW);
        bus.mem_wr = (r_opcode == OP_SW);
      end
      S_WB: begin
        bus.reg_wr     = 1'b1;
        bus.reg_dst    = (r_opcode == OP_R);
        bus.mem_to_reg = (r_opcode == OP_LW);
      end
      default: ;
    endcase
    if (bus.stall) begin
      bus.pc_wr  = 1'b0;
      bus.ir_wr  = 1'b0;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
      bus.reg_wr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: each step drives the
// inputs for one cycle, queues the expected state/strobes/flags and then
// checks them on the falling edge.
module tb_multicycle_control;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5, S_IDLE = 3'd6;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_J = 6'b000010;
`ifdef CTRL_RETIRE_CNT_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif
  localparam logic [15:0] C_IDLE = 16'h0000;
  localparam logic [15:0] C_TRAP = 16'h0001;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic        to;
    logic [15:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic        exp_ill = 1'b0;
  logic        exp_to  = 1'b0;
  logic [15:0] exp_ret = 16'd0;

  multicycle_control_if #(.CNT_W(16)) bus ();

  multicycle_control #(.TIMEOUT_W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {pc_wr, pc_src, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, reg_dst,
  //  mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op}
  function automatic logic [15:0] pk(input logic pw, input logic [1:0] ps, input logic iw,
      input logic iod, input logic mr, input logic mw, input logic rw, input logic rdst,
      input logic m2r, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
      input logic ext);
    return {pw, ps, iw, iod, mr, mw, rw, rdst, m2r, asa, asb, aop, ext};
  endfunction

  // Clear pc_wr, ir_wr, mem_rd, mem_wr and reg_wr
  function automatic logic [15:0] stl(input logic [15:0] c);
    return c & ~16'h9700;
  endfunction

  function automatic logic [15:0] c_fetch(input logic r);
    return pk(r, 2'b00, r, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1);
  endfunction

  function automatic logic [15:0] c_dec(input logic j);
    return pk(j, j ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              2'b11, 2'b00, 1'b1);
  endfunction

  function automatic logic [15:0] c_exec(input logic [5:0] op, input logic z);
    case (op)
      OP_R:    return pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1);
      OP_ANDI: return pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11, 1'b0);
      OP_BEQ:  return pk(z,    2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1);
      OP_BNE:  return pk(~z,   2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1);
      default: return pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1);
    endcase
  endfunction

  function automatic logic [15:0] c_mem(input logic [5:0] op);
    return pk(1'b0, 2'b00, 1'b0, 1'b1, op == OP_LW, op == OP_SW, 1'b0, 1'b0, 1'b0, 1'b0,
              2'b00, 2'b00, 1'b1);
  endfunction

  function automatic logic [15:0] c_wb(input logic [5:0] op);
    return pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, op == OP_R, op == OP_LW, 1'b0,
              2'b00, 2'b00, 1'b1);
  endfunction

  // One cycle: drive inputs, queue expectation, check at the falling edge
  task automatic step(input string tag, input logic rdy, input logic z, input logic stall_in,
                      input logic [2:0] st, input logic [15:0] ctl);
    exp_t e;
    exp_t got;
    logic [15:0] obs;
    bus.mem_ready = rdy;
    bus.zero      = z;
    bus.stall     = stall_in;
    e.tag = tag; e.st = st; e.ctl = ctl; e.ill = exp_ill; e.to = exp_to; e.ret = exp_ret;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    obs = pk(bus.pc_wr, bus.pc_src, bus.ir_wr, bus.i_or_d, bus.mem_rd, bus.mem_wr,
             bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
             bus.alu_op, bus.ext_op);
    $display("step %-14s state=%0d ctl=%04h ill=%b to=%b ret=%0d", got.tag, bus.state, obs,
             bus.illegal, bus.timeout, bus.retired);
    n_vec++;
    assert (bus.state === got.st) else begin
      n_bad++; $error("FAIL %s.state observed %0d expected %0d", got.tag, bus.state, got.st);
    end
    n_vec++;
    assert (obs === got.ctl) else begin
      n_bad++; $error("FAIL %s.ctl observed %04h expected %04h", got.tag, obs, got.ctl);
    end
    n_vec++;
    assert (bus.illegal === got.ill) else begin
      n_bad++; $error("FAIL %s.illegal observed %b expected %b", got.tag, bus.illegal, got.ill);
    end
    n_vec++;
    assert (bus.timeout === got.to) else begin
      n_bad++; $error("FAIL %s.timeout observed %b expected %b", got.tag, bus.timeout, got.to);
    end
    n_vec++;
    assert (bus.retired === got.ret) else begin
      n_bad++; $error("FAIL %s.retired observed %0d expected %0d", got.tag, bus.retired, got.ret);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    if (RET_EN) exp_ret = exp_ret + 16'd1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.inst = 32'd0; bus.mem_ready = 1'b0; bus.zero = 1'b0; bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("rst_hold", 1'b1, 1'b0, 1'b0, S_IDLE, C_IDLE);
    rst_n = 1'b1;
    step("idle", 1'b1, 1'b0, 1'b0, S_IDLE, C_IDLE);

    // add $3,$1,$2
    bus.inst = {OP_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
    step("add_fetch", 1'b1, 1'b0, 1'b0, S_FETCH, c_fetch(1'b1));
    step("add_dec",   1'b1, 1'b0, 1'b0, S_DECODE, c_dec(1'b0));
    step("add_exec",  1'b1, 1'b0, 1'b0, S_EXEC, c_exec(OP_R, 1'b0));
    step("add_wb",    1'b1, 1'b0, 1'b0, S_WB, c_wb(OP_R));
    bump();
    step("fetch_stall", 1'b1, 1'b0, 1'b1, S_FETCH, stl(c_fetch(1'b1)));

    // lw with three wait cycles in MEM
    bus.inst = {OP_LW, 26'h0};
    step("lw_fetch", 1'b1, 1'b0, 1'b0, S_FETCH, c_fetch(1'b1));
    step("lw_dec",   1'b1, 1'b0, 1'b0, S_DECODE, c_dec(1'b0));
    step("lw_exec",  1'b1, 1'b0, 1'b0, S_EXEC, c_exec(OP_LW, 1'b0));
    for (int i = 0; i < 3; i++) step("lw_mem_wait", 1'b0, 1'b0, 1'b0, S_MEM, c_mem(OP_LW));
    step("lw_mem_done", 1'b1, 1'b0, 1'b0, S_MEM, c_mem(OP_LW));
    step("lw_wb",       1'b1, 1'b0, 1'b0, S_WB, c_wb(OP_LW));
    bump();

    // beq taken, bne not taken, both with zero=1
    bus.inst = {OP_BEQ, 26'h0};
    step("beq_fetch", 1'b1, 1'b1, 1'b0, S_FETCH, c_fetch(1'b1));
    step("beq_dec",   1'b1, 1'b1, 1'b0, S_DECODE, c_dec(1'b0));
    step("beq_exec",  1'b1, 1'b1, 1'b0, S_EXEC, c_exec(OP_BEQ, 1'b1));
    bump();
    bus.inst = {OP_BNE, 26'h0};
    step("bne_fetch", 1'b1, 1'b1, 1'b0, S_FETCH, c_fetch(1'b1));
    step("bne_dec",   1'b1, 1'b1, 1'b0, S_DECODE, c_dec(1'b0));
    step("bne_exec",  1'b1, 1'b1, 1'b0, S_EXEC, c_exec(OP_BNE, 1'b1));
    bump();

    // addi and andi
    bus.inst = {OP_ADDI, 26'h0};
    step("addi_fetch", 1'b1, 1'b0, 1'b0, S_FETCH, c_fetch(1'b1));
    step("addi_dec",   1'b1, 1'b0, 1'b0, S_DECODE, c_dec(1'b0));
    step("addi_exec",  1'b1, 1'b0, 1'b0, S_EXEC, c_exec(OP_ADDI, 1'b0));
    step("addi_wb",    1'b1, 1'b0, 1'b0, S_WB, c_wb(OP_ADDI));
    bump();
    bus.inst = {OP_ANDI, 26'h0};
    step("andi_fetch", 1'b1, 1'b0, 1'b0, S_FETCH, c_fetch(1'b1));
    step("andi_dec",   1'b1, 1'b0, 1'b0, S_DECODE, c_dec(1'b0));
    step("andi_exec",  1'b1, 1'b0, 1'b0, S_EXEC, c_exec(OP_ANDI, 1'b0));
    step("andi_wb",    1'b1, 1'b0, 1'b0, S_WB, c_wb(OP_ANDI));
    bump();

    // j
    bus.inst = {OP_J, 26'h0};
    step("j_fetch", 1'b1, 1'b0, 1'b0, S_FETCH, c_fetch(1'b1));
    step("j_dec",   1'b1, 1'b0, 1'b0, S_DECODE, c_dec(1'b1));
    bump();

    // sw stalled twice in MEM with mem_ready high
    bus.inst = {OP_SW, 26'h0};
    step("sw_fetch", 1'b1, 1'b0, 1'b0, S_FETCH, c_fetch(1'b1));
    step("sw_dec",   1'b1, 1'b0, 1'b0, S_DECODE, c_dec(1'b0));
    step("sw_exec",  1'b1, 1'b0, 1'b0, S_EXEC, c_exec(OP_SW, 1'b0));
    for (int i = 0; i < 2; i++) step("sw_mem_stall", 1'b1, 1'b0, 1'b1, S_MEM, stl(c_mem(OP_SW)));
    step("sw_mem", 1'b1, 1'b0, 1'b0, S_MEM, c_mem(OP_SW));
    bump();

    // Watchdog near miss: ready arrives on the 15th cycle
    bus.inst = {OP_J, 26'h0};
    for (int i = 0; i < 14; i++) step("wd_wait", 1'b0, 1'b0, 1'b0, S_FETCH, c_fetch(1'b0));
    step("wd_last_ready", 1'b1, 1'b0, 1'b0, S_FETCH, c_fetch(1'b1));
    step("wd_dec",        1'b1, 1'b0, 1'b0, S_DECODE, c_dec(1'b1));
    bump();

    // Illegal opcode traps from DECODE
    bus.inst = {6'b111111, 26'h0};
    step("ill_fetch", 1'b1, 1'b0, 1'b0, S_FETCH, c_fetch(1'b1));
    step("ill_dec",   1'b1, 1'b0, 1'b0, S_DECODE, c_dec(1'b0));
    exp_ill = 1'b1;
    for (int i = 0; i < 3; i++) step("ill_trap", 1'b1, 1'b1, 1'b0, S_TRAP, C_TRAP);

    rst_n = 1'b0; exp_ill = 1'b0; exp_ret = 16'd0;
    step("rst2", 1'b0, 1'b0, 1'b0, S_IDLE, C_IDLE);
    rst_n = 1'b1;
    step("idle2", 1'b0, 1'b0, 1'b0, S_IDLE, C_IDLE);

    // Watchdog expiry: 15 not-ready FETCH cycles
    for (int i = 0; i < 14; i++) step("to_wait", 1'b0, 1'b0, 1'b0, S_FETCH, c_fetch(1'b0));
    step("to_last", 1'b0, 1'b0, 1'b0, S_FETCH, c_fetch(1'b0));
    exp_to = 1'b1;
    for (int i = 0; i < 2; i++) step("to_trap", 1'b1, 1'b0, 1'b0, S_TRAP, C_TRAP);

    rst_n = 1'b0; exp_to = 1'b0; exp_ret = 16'd0;
    step("rst3", 1'b0, 1'b0, 1'b0, S_IDLE, C_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
